// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with freeze, flush/bubble NOP insertion and slot valid tracking
// Optional BUBBLE_CNT_EN adds a saturating 16-bit count of inserted NOPs on bubble_cnt_out.
module id_exe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  imm_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            sr_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic                  imm_out,
  output logic [3:0]            exe_cmd_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            sr_out,
  output logic                  valid_out
`ifdef BUBBLE_CNT_EN
  ,
  output logic [15:0]           bubble_cnt_out
`endif
);
  logic nop;
  assign nop = flush | bubble;
  // capture the ID slot; freeze holds everything, flush/bubble load an all-zero NOP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      imm_out           <= 1'b0;
      exe_cmd_out       <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      sr_out            <= '0;
      valid_out         <= 1'b0;
    end else if (!freeze) begin
      pc_out            <= nop ? '0 : pc_in;
      wb_en_out         <= !nop && wb_en_in;
      mem_r_en_out      <= !nop && mem_r_en_in;
      mem_w_en_out      <= !nop && mem_w_en_in;
      b_out             <= !nop && b_in;
      s_out             <= !nop && s_in;
      imm_out           <= !nop && imm_in;
      exe_cmd_out       <= nop ? '0 : exe_cmd_in;
      val_rn_out        <= nop ? '0 : val_rn_in;
      val_rm_out        <= nop ? '0 : val_rm_in;
      shift_operand_out <= nop ? '0 : shift_operand_in;
      signed_imm_24_out <= nop ? '0 : signed_imm_24_in;
      dest_out          <= nop ? '0 : dest_in;
      src1_out          <= nop ? '0 : src1_in;
      src2_out          <= nop ? '0 : src2_in;
      sr_out            <= nop ? '0 : sr_in;
      valid_out         <= !nop;
    end
`ifdef BUBBLE_CNT_EN
  // count NOP insertions, saturating at all-ones so it never wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) bubble_cnt_out <= '0;
    else if (!freeze && nop && bubble_cnt_out != 16'hFFFF) bubble_cnt_out <= bubble_cnt_out + 16'd1;
`endif
endmodule
